// File: rtl/transmit_if.sv
// Host-side bus of the UART transmitter: word, valid/ready handshake,
// serial line and end-of-frame pulse.
interface transmit_if;
  logic [7:0] data;
  logic       send;
  logic       ready;
  logic       txd;
  logic       done;

  modport master (output data, send, input ready, txd, done);
  modport slave  (input data, send, output ready, txd, done);
endinterface

// File: rtl/transmit.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity,
// then STOP_BITS stop bits, each bit held CLKS_PER_BIT clocks.
// Optional feature macro: TX_PARITY_EN (adds an even-parity bit after bit 7).
// A new word may be accepted in the last cycle of the last stop bit, so
// frames can run back to back with no idle gap.
module transmit #(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     rst,
  transmit_if.slave bus
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             done_q, done_d;
`ifdef TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic bit_end;
  logic last_stop;
  logic ready_w;
  logic accept;

  assign bit_end   = (cnt_q == CNT_LAST);
  assign last_stop = (state_q == ST_STOP) && (idx_q == STOP_LAST) && bit_end;
  assign ready_w   = (state_q == ST_IDLE) || last_stop;
  assign accept    = bus.send && ready_w;

  assign bus.ready = ready_w;
  assign bus.txd   = txd_q;
  assign bus.done  = done_q;

  // Next-state, counters, shift register and registered line level
  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
`ifdef TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d  = ST_START;
          shift_d  = bus.data;
          idx_d    = 3'd0;
`ifdef TX_PARITY_EN
          parity_d = ^bus.data;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
`ifdef TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          idx_d   = 3'd0;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            done_d = 1'b1;
            idx_d  = 3'd0;
            if (accept) begin
              // Chain straight into the next frame's start bit.
              state_d  = ST_START;
              shift_d  = bus.data;
`ifdef TX_PARITY_EN
              parity_d = ^bus.data;
`endif
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the state being entered so txd is a clean flop.
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef TX_PARITY_EN
      ST_PARITY: txd_d = parity_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'd0;
      txd_q    <= 1'b1;
      done_q   <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      done_q   <= done_d;
`ifdef TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_transmit.sv
// Bench for transmit: three instances with different bit times / stop bits,
// directed and random frames compared against a per-cycle frame model.
module tb_transmit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int         sel = 0;
  logic       send_r = 1'b0;
  logic [7:0] data_r = 8'h00;
  logic       obs_txd, obs_ready, obs_done;

  transmit_if if0 ();
  transmit_if if1 ();
  transmit_if if2 ();

  assign if0.send = send_r && (sel == 0);
  assign if1.send = send_r && (sel == 1);
  assign if2.send = send_r && (sel == 2);
  assign if0.data = data_r;
  assign if1.data = data_r;
  assign if2.data = data_r;

  transmit #(.CLKS_PER_BIT(1), .STOP_BITS(1)) u_t0 (.clk(clk), .rst(rst), .bus(if0));
  transmit #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_t1 (.clk(clk), .rst(rst), .bus(if1));
  transmit #(.CLKS_PER_BIT(2), .STOP_BITS(2)) u_t2 (.clk(clk), .rst(rst), .bus(if2));

  always_comb begin
    case (sel)
      0:       begin obs_txd = if0.txd; obs_ready = if0.ready; obs_done = if0.done; end
      1:       begin obs_txd = if1.txd; obs_ready = if1.ready; obs_done = if1.done; end
      default: begin obs_txd = if2.txd; obs_ready = if2.ready; obs_done = if2.done; end
    endcase
  end

  function automatic int cpb(input int s);
    return (s == 0) ? 1 : (s == 1) ? 4 : 2;
  endfunction

  function automatic int nstop(input int s);
    return (s == 2) ? 2 : 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line levels, one entry per clock of the frame.
  task automatic build(input int s, input logic [7:0] d, output logic q[$]);
    int c;
    c = cpb(s);
    q = {};
    for (int k = 0; k < c; k++) q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < c; k++) q.push_back(d[i]);
`ifdef TX_PARITY_EN
    for (int k = 0; k < c; k++) q.push_back(^d);
`endif
    for (int k = 0; k < c * nstop(s); k++) q.push_back(1'b1);
  endtask

  // Entered in a cycle where ready must be high; returns in the frame's
  // last cycle. hold keeps send asserted (data = nd) for chaining; poke
  // pulses send with 0xFF at frame cycle 'poke'.
  task automatic run_frame(input int s, input logic [7:0] d, input bit done_first,
                           input bit hold, input logic [7:0] nd, input int poke);
    logic q[$];
    int   f;
    build(s, d, q);
    f = q.size();
    chk($sformatf("accept_ready s%0d d%02h", s, d), obs_ready, 1);
    data_r = d;
    send_r = 1'b1;
    step();
    if (hold) data_r = nd;
    else send_r = 1'b0;
    for (int j = 1; j <= f; j++) begin
      if (poke != 0 && j == poke) begin send_r = 1'b1; data_r = 8'hFF; end
      if (poke != 0 && j == poke + 1) send_r = 1'b0;
      chk($sformatf("txd s%0d d%02h c%0d", s, d, j), obs_txd, q[j-1]);
      chk($sformatf("ready s%0d d%02h c%0d", s, d, j), obs_ready, (j == f));
      chk($sformatf("done s%0d d%02h c%0d", s, d, j), obs_done, (j == 1) && done_first);
      if (j < f) step();
    end
  endtask

  task automatic end_frame(input int s);
    send_r = 1'b0;
    step();
    chk($sformatf("done_pulse s%0d", s), obs_done, 1);
    chk($sformatf("idle_txd s%0d", s), obs_txd, 1);
    chk($sformatf("idle_ready s%0d", s), obs_ready, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post_done s%0d", s), obs_done, 0);
      chk($sformatf("post_txd s%0d", s), obs_txd, 1);
      chk($sformatf("post_ready s%0d", s), obs_ready, 1);
    end
  endtask

  // Directed steps followed by random frames
  initial begin
    logic q[$];
    logic [7:0] d, d2;
    int s;

    // Reset and idle
    rst = 1'b1;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #0;
      chk("rst_txd", obs_txd, 1);
      chk("rst_ready", obs_ready, 1);
      chk("rst_done", obs_done, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        sel = k;
        #0;
        chk("idle_txd", obs_txd, 1);
        chk("idle_ready", obs_ready, 1);
        chk("idle_done", obs_done, 0);
      end
    end

    // Basic frame, one clock per bit
    sel = 0;
    run_frame(0, 8'hA5, 0, 0, 8'h00, 0);
    end_frame(0);

    // Slow baud, send held high across two back-to-back frames
    sel = 1;
    run_frame(1, 8'h00, 0, 1, 8'hFF, 0);
    run_frame(1, 8'hFF, 1, 0, 8'h00, 0);
    end_frame(1);

    // Send pulsed during data bit 2 must be ignored
    run_frame(1, 8'h3C, 0, 0, 8'h00, 13);
    end_frame(1);

    // Reset during data bit 3, with send raised alongside it
    sel = 0;
    build(0, 8'h81, q);
    data_r = 8'h81;
    send_r = 1'b1;
    step();
    send_r = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      chk($sformatf("pre_rst_txd c%0d", j), obs_txd, q[j-1]);
      if (j < 5) step();
    end
    rst = 1'b1;
    send_r = 1'b1;
    step();
    chk("rst_mid_txd", obs_txd, 1);
    chk("rst_mid_ready", obs_ready, 1);
    chk("rst_mid_done", obs_done, 0);
    rst = 1'b0;
    send_r = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("after_rst_txd", obs_txd, 1);
      chk("after_rst_done", obs_done, 0);
    end
    run_frame(0, 8'h81, 0, 0, 8'h00, 0);
    end_frame(0);

    // Two stop bits (and parity when built with it)
    sel = 2;
    run_frame(2, 8'h07, 0, 0, 8'h00, 0);
    end_frame(2);
    run_frame(2, 8'h03, 0, 0, 8'h00, 0);
    end_frame(2);

    // Random words on random instances, sometimes chained
    for (int n = 0; n < 16; n++) begin
      s   = $urandom_range(0, 2);
      sel = s;
      d   = 8'($urandom_range(0, 255));
      d2  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        run_frame(s, d, 0, 1, d2, 0);
        run_frame(s, d2, 1, 0, 8'h00, 0);
      end else begin
        run_frame(s, d, 0, 0, 8'h00, 0);
      end
      end_frame(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transmit.md
# transmit

UART transmitter: serialises an 8-bit word onto `txd` as start bit, eight data bits LSB first, then stop bit(s). It is the transmit side of the team's UART interface controller and pairs with the receive block. With `CLKS_PER_BIT = 1` it produces exactly the one-bit-per-clock frame the receiver samples. The host loads words through a single-entry valid/ready handshake.

## Interface
- `CLKS_PER_BIT`, default 1: clk cycles each bit is held on `txd`. Legal values are ≥1.
- `STOP_BITS`, default 1: number of stop bits per frame. Legal values are 1 or 2.
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `data`, input, 8: word to send. Sampled only on the accept edge.
- `send`, input, 1: request to transmit `data`.
- `ready`, output, 1: the block accepts `send` this cycle.
- `txd`, output, 1: serial line, idle high. Registered.
- `done`, output, 1: one-cycle pulse after a frame's last stop bit completes.

## Operation
- Accept occurs on the rising edge where `send && ready` is high. On that edge `data` is latched into the shift register. A `send` while `ready` is low is ignored; there is no queue.
- FSM states are IDLE, START, DATA, PARITY (only when the macro is defined) and STOP.
  - IDLE → START on accept.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → PARITY or STOP after 8 bits.
  - PARITY → STOP after one bit.
  - STOP → IDLE after `STOP_BITS` bit periods, or STOP → START directly if accept occurs in the final stop cycle.
- Line levels by state:
  - START: `txd` = 0.
  - DATA: `txd` = shift register bit 0. The register shifts right once per bit period.
  - STOP and IDLE: `txd` = 1.
- The bit-period counter has width `$clog2(CLKS_PER_BIT)+1`. It reloads at every bit boundary. The bit index is a 3-bit counter, 0..7, and does not wrap within a frame.
- `ready` = 1 in IDLE, and in the last clk cycle of the last stop bit. This gives back-to-back frames with no idle gap.
- Reset values: `txd` = 1, `ready` = 1, `done` = 0, state IDLE, all counters 0, shift register 0.
- Reset mid-frame aborts the frame. `txd` returns to 1 on the cycle after the reset edge. No `done` is produced for the aborted frame.
- Reset takes priority over a simultaneous `send`.

## Timing
- Define F = (1 + 8 + P + STOP_BITS) × `CLKS_PER_BIT`, where P = 1 with the parity macro and 0 without.
- If accept occurs at edge k:
  - `txd` start bit is driven during cycles k+1 … k+`CLKS_PER_BIT`.
  - Data bit i is driven during cycles k+1+(1+i)·`CLKS_PER_BIT` onward, for `CLKS_PER_BIT` cycles.
  - `ready` is low for cycles k+1 … k+F−1 and high at cycle k+F.
  - `done` is high for exactly cycle k+F+1.
- Latency from accept to the first start-bit cycle is 1 clk.
- The throughput ceiling is one frame per F cycles.

## Configuration
- `TX_PARITY_EN` defined: an even-parity bit equal to `^data` is inserted after data bit 7, for one bit period. The frame grows by `CLKS_PER_BIT` cycles.
- `TX_PARITY_EN` undefined: no PARITY state and no parity bit. The frame is start, 8 data bits, then stop. This mode is compatible with the receive block.

## Test plan
- **Reset/idle:** assert `rst` for 2 cycles, then hold `send` = 0 for 20 cycles. Required: `txd` = 1, `ready` = 1, `done` = 0 throughout.
- **Basic frame:** `CLKS_PER_BIT` = 1, accept 0xA5 at edge 0. Required:
  - `txd` over cycles 1..10 = 0,1,0,1,0,0,1,0,1,1.
  - `ready` low over cycles 1..9 and high at cycle 10; `done` high at cycle 11.
  - Looped into the receive block, `word` = 0xA5.
- **Slow baud and back-to-back:** `CLKS_PER_BIT` = 4, hold `send` high with 0x00 then 0xFF. Required:
  - Each level is held for exactly 4 cycles.
  - The second start bit begins on the cycle directly after the first frame's stop bit ends.
  - Frames are 40 cycles each, with `done` pulsing once per frame.
- **Ignored send:** while 0x3C is in its DATA state, pulse `send` with `data` = 0xFF. Required: the 0x3C waveform is unchanged and there is no extra frame.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0x81. Required:
  - `txd` = 1 and `ready` = 1 on the next cycle.
  - `done` stays 0.
  - A new accept afterwards yields a clean frame.
- **Parity and stop bits (`TX_PARITY_EN` defined, `STOP_BITS` = 2):**
  - Send 0x07. Required: parity bit = 1 at cycle 10, `txd` = 1 over cycles 11..12, frame length 12.
  - Send 0x03. Required: parity bit = 0.
